// File: rtl/line_scheduler_if.sv
`default_nettype none
// ============================================================================
// Interface : line_scheduler_if
// Brief     : Option-RAM read port and solver stream between scheduler and solver.
// Revision  : 1.0 - initial release
// ============================================================================
interface line_scheduler_if #(
  parameter int SIZE     = 3,
  parameter int MAX_OPTS = 8
);
  localparam int c_addrw = $clog2(2 * SIZE * MAX_OPTS);

  logic               mem_rd;
  logic [c_addrw-1:0] mem_addr;
  logic [SIZE-1:0]    mem_data;

  logic               sol_valid;
  logic [SIZE-1:0]    sol_data;
  logic               sol_first;
  logic               sol_ready;
  logic               sol_done;
  logic               sol_put_back;
  logic               sol_progress;

  modport master (
    output mem_rd, mem_addr,
    input  mem_data,
    output sol_valid, sol_data, sol_first,
    input  sol_ready, sol_done, sol_put_back, sol_progress
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_data,
    input  sol_valid, sol_data, sol_first,
    output sol_ready, sol_done, sol_put_back, sol_progress
  );
endinterface
`default_nettype wire

// File: rtl/line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : line_scheduler
// Brief    : Circular work queue of board lines; streams each line's index and
//            candidate options to the solver and re-queues unresolved lines.
// Revision : 1.0 - initial release
// ============================================================================
module line_scheduler #(
  parameter int SIZE     = 3,
  parameter int MAX_OPTS = 8,
  parameter int CNTW     = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cnt_we,
  input  logic [$clog2(2*SIZE)-1:0] cnt_idx,
  input  logic [CNTW-1:0]           cnt_data,
  line_scheduler_if.master          bus,
  output logic                      busy,
  output logic                      done,
  output logic                      stuck
);
  localparam int c_lines = 2 * SIZE;
  localparam int c_idxw  = $clog2(c_lines);
  localparam int c_addrw = $clog2(c_lines * MAX_OPTS);
  localparam int c_kb    = $clog2(MAX_OPTS);
  localparam int c_kw    = (c_kb > 0) ? c_kb : 1;
  localparam int c_ow    = $clog2(c_lines + 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INIT      = 4'd1,
    S_POP       = 4'd2,
    S_SEND_IDX  = 4'd3,
    S_FETCH     = 4'd4,
    S_LOAD      = 4'd5,
    S_SEND_OPT  = 4'd6,
    S_WAIT_DONE = 4'd7,
    S_DONE      = 4'd8,
    S_STUCK     = 4'd9
  } state_t;

  state_t              r_state;
  logic [CNTW-1:0]     r_cnt [c_lines];
  logic [c_idxw-1:0]   r_q   [c_lines];
  logic [c_lines-1:0]  r_pend;
  logic [c_idxw-1:0]   r_head, r_tail, r_cur, r_init;
  logic [c_ow-1:0]     r_occ, r_np;
  logic [c_kw-1:0]     r_k;
  logic                r_busy, r_done, r_stuck;
  logic                r_sol_valid, r_sol_first, r_mem_rd;
  logic [SIZE-1:0]     r_sol_data;
  logic [c_addrw-1:0]  r_mem_addr;

  logic [CNTW-1:0]     w_cur_cnt, w_cnt_wr;
  logic                w_cfg_ok, w_push, w_last, w_stall;
  logic [c_ow-1:0]     w_np_next, w_occ_next;

  function automatic logic [c_idxw-1:0] f_next(input logic [c_idxw-1:0] idx);
    return (idx == c_idxw'(c_lines - 1)) ? '0 : idx + c_idxw'(1);
  endfunction

  function automatic logic [c_addrw-1:0] f_addr(input logic [c_idxw-1:0] line,
                                                input logic [c_kw-1:0]   k);
    return (c_addrw'(line) << c_kb) | c_addrw'(k);
  endfunction

  assign w_cfg_ok   = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_STUCK);
  assign w_cnt_wr   = (int'(cnt_data) > MAX_OPTS) ? CNTW'(MAX_OPTS) : cnt_data;
  assign w_cur_cnt  = r_cnt[r_cur];
  assign w_last     = (CNTW'(r_k) + CNTW'(1)) == w_cur_cnt;
  // The pending bit is the duplicate guard, so the queue can never overflow.
  assign w_push     = bus.sol_put_back && !r_pend[r_cur];
  assign w_np_next  = bus.sol_progress ? '0 : r_np + c_ow'(1);
  assign w_occ_next = r_occ + c_ow'(w_push);
  assign w_stall    = (w_np_next >= w_occ_next) && (w_occ_next != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_pend      <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_cur       <= '0;
      r_init      <= '0;
      r_occ       <= '0;
      r_np        <= '0;
      r_k         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_stuck     <= 1'b0;
      r_sol_valid <= 1'b0;
      r_sol_first <= 1'b0;
      r_sol_data  <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      for (int i = 0; i < c_lines; i++) begin
        r_cnt[i] <= '0;
        r_q[i]   <= '0;
      end
    end else begin
      if (w_cfg_ok && cnt_we && (int'(cnt_idx) < c_lines))
        r_cnt[cnt_idx] <= w_cnt_wr;

      case (r_state)
        S_IDLE, S_DONE, S_STUCK: begin
          if (start) begin
            r_state <= S_INIT;
            r_done  <= 1'b0;
            r_stuck <= 1'b0;
            r_busy  <= 1'b1;
            r_np    <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_occ   <= '0;
            r_pend  <= '0;
            r_init  <= '0;
          end
        end
        S_INIT: begin
          r_q[r_tail]    <= r_init;
          r_pend[r_init] <= 1'b1;
          r_tail         <= f_next(r_tail);
          r_occ          <= r_occ + c_ow'(1);
          r_init         <= r_init + c_idxw'(1);
          if (r_init == c_idxw'(c_lines - 1))
            r_state <= S_POP;
        end
        S_POP: begin
          if (r_occ == '0) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cur              <= r_q[r_head];
            r_pend[r_q[r_head]] <= 1'b0;
            r_head             <= f_next(r_head);
            r_occ              <= r_occ - c_ow'(1);
            r_k                <= '0;
            r_sol_valid        <= 1'b1;
            r_sol_first        <= 1'b1;
            r_sol_data         <= SIZE'(r_q[r_head]);
            r_state            <= S_SEND_IDX;
          end
        end
        S_SEND_IDX: begin
          if (bus.sol_ready) begin
            r_sol_valid <= 1'b0;
            r_sol_first <= 1'b0;
            if (w_cur_cnt == '0) begin
              r_state <= S_WAIT_DONE;
            end else begin
              r_mem_rd   <= 1'b1;
              r_mem_addr <= f_addr(r_cur, r_k);
              r_state    <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          r_mem_rd <= 1'b0;
          r_state  <= S_LOAD;
        end
        S_LOAD: begin
          r_sol_data  <= bus.mem_data;
          r_sol_valid <= 1'b1;
          r_state     <= S_SEND_OPT;
        end
        S_SEND_OPT: begin
          if (bus.sol_ready) begin
            r_sol_valid <= 1'b0;
            if (w_last) begin
              r_state <= S_WAIT_DONE;
            end else begin
              r_k        <= r_k + c_kw'(1);
              r_mem_rd   <= 1'b1;
              r_mem_addr <= f_addr(r_cur, r_k + c_kw'(1));
              r_state    <= S_FETCH;
            end
          end
        end
        S_WAIT_DONE: begin
          if (bus.sol_done) begin
            if (w_push) begin
              r_q[r_tail]   <= r_cur;
              r_tail        <= f_next(r_tail);
              r_pend[r_cur] <= 1'b1;
            end
            r_occ <= w_occ_next;
            r_np  <= w_np_next;
            if (w_stall) begin
              r_state <= S_STUCK;
              r_stuck <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_POP;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.sol_valid = r_sol_valid;
  assign bus.sol_first = r_sol_first;
  assign bus.sol_data  = r_sol_data;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_addr  = r_mem_addr;
  assign busy          = r_busy;
  assign done          = r_done;
  assign stuck         = r_stuck;
endmodule
`default_nettype wire

// File: tb/tb_line_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_scheduler
// Brief    : Directed + randomized bench with a queue-level scheduler model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_scheduler;
  localparam int SIZE     = 3;
  localparam int MAX_OPTS = 8;
  localparam int CNTW     = 7;
  localparam int LINES    = 2 * SIZE;
  localparam int IDXW     = $clog2(LINES);
  localparam int P_BOARD  = 0;
  localparam int P_NOPROG = 1;
  localparam int P_NONE   = 2;
  localparam int P_RANDOM = 3;

  logic            clk      = 1'b0;
  logic            rst      = 1'b0;
  logic            start    = 1'b0;
  logic            cnt_we   = 1'b0;
  logic [IDXW-1:0] cnt_idx  = '0;
  logic [CNTW-1:0] cnt_data = '0;
  logic            busy, done, stuck;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_cnt  = 0;
  int dut_lines;
  int order_q[$];
  int model_cnt [LINES];
  int exp_order [10] = '{0, 1, 2, 3, 4, 5, 0, 1, 4, 5};
  logic [SIZE-1:0] ram [LINES*MAX_OPTS];

  line_scheduler_if #(.SIZE(SIZE), .MAX_OPTS(MAX_OPTS)) bus ();

  line_scheduler #(.SIZE(SIZE), .MAX_OPTS(MAX_OPTS), .CNTW(CNTW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cnt_we   (cnt_we),
    .cnt_idx  (cnt_idx),
    .cnt_data (cnt_data),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .stuck    (stuck)
  );

  always #5 clk = ~clk;

  // Option RAM with one cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_rd) begin
      bus.mem_data <= ram[bus.mem_addr];
      rd_cnt       <= rd_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void decide(input int policy, input int comp, input int line,
                                 output bit pb, output bit pg);
    case (policy)
      P_BOARD:  begin pb = (comp < LINES) && (line == 0 || line == 1 || line == 4 || line == 5); pg = 1'b1; end
      P_NOPROG: begin pb = 1'b1; pg = 1'b0; end
      P_NONE:   begin pb = 1'b0; pg = 1'b1; end
      default:  begin pb = (comp < 16) && ($urandom_range(0, 1) != 0); pg = ($urandom_range(0, 2) != 0); end
    endcase
  endfunction

  task automatic write_cnt(input int idx, input int val);
    @(negedge clk);
    cnt_we   = 1'b1;
    cnt_idx  = IDXW'(idx);
    cnt_data = CNTW'(val);
    @(negedge clk);
    cnt_we   = 1'b0;
    model_cnt[idx] = (val > MAX_OPTS) ? MAX_OPTS : val;
  endtask

  task automatic wait_flag(input string tag, input bit want_stuck);
    int t = 0;
    while (!(want_stuck ? stuck : done) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk(tag, want_stuck ? stuck : done, 1);
  endtask

  task automatic run_solve(input int policy, input bit rand_ready, input int stall_line);
    int mq[$];
    int exp_w[$];
    int np, line, t, rd0, rd_hold, hold, stall_left, comp, prev_acc, gap;
    bit pb, pg, acc, stall_done, stalled, seen;
    logic [SIZE-1:0] held;
    order_q.delete();
    dut_lines = 0; comp = 0; np = 0; stall_done = 0; held = '0; rd_hold = 0;
    for (int i = 0; i < LINES; i++) mq.push_back(i);
    @(negedge clk);
    start = 1'b1;
    bus.sol_ready = !rand_ready;
    @(negedge clk);
    start = 1'b0;
    chk("busy_on_start", busy, 1);
    chk("done_cleared", done, 0);
    chk("stuck_cleared", stuck, 0);
    while (1) begin
      if (mq.size() == 0) begin
        wait_flag("done_flag", 1'b0);
        chk("done_busy", busy, 0);
        chk("done_no_stuck", stuck, 0);
        return;
      end
      line = mq.pop_front();
      exp_w.delete();
      exp_w.push_back(line);
      for (int k = 0; k < model_cnt[line]; k++) exp_w.push_back(int'(ram[line*MAX_OPTS+k]));
      rd0 = rd_cnt; stalled = 0; prev_acc = 0;
      for (int w = 0; w < exp_w.size(); w++) begin
        acc = 0; t = 0; hold = 0;
        stall_left = (line == stall_line && w == 2 && !stall_done) ? 4 : 0;
        while (!acc) begin
          if (bus.sol_valid) begin
            if (hold == 0) begin
              chk("word_data", bus.sol_data, exp_w[w]);
              chk("word_first", bus.sol_first, w == 0);
              held = bus.sol_data;
              rd_hold = rd_cnt;
            end else begin
              chk("hold_data", bus.sol_data, held);
              chk("hold_no_rd", rd_cnt, rd_hold);
            end
            if (stall_left > 0) begin
              bus.sol_ready = 1'b0;
              stall_left--;
              stall_done = 1;
              stalled = 1;
            end else begin
              bus.sol_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            if (bus.sol_ready) begin
              acc = 1;
              if (w == 0) begin
                order_q.push_back(int'(bus.sol_data));
                dut_lines++;
              end
              if (w > 0 && !rand_ready && !stalled) chk("throughput", cyc - prev_acc, 3);
              prev_acc = cyc;
            end else begin
              hold++;
              // A completion pulse outside WAIT_DONE must leave the queue alone.
              if (rand_ready && $urandom_range(0, 1) != 0) begin
                bus.sol_done = 1'b1; bus.sol_put_back = 1'b1; bus.sol_progress = 1'b1;
              end
            end
          end else if (rand_ready) begin
            bus.sol_ready = 1'($urandom_range(0, 1));
          end
          @(negedge clk);
          bus.sol_done = 1'b0; bus.sol_put_back = 1'b0; bus.sol_progress = 1'b0;
          t++;
          if (!acc && t > 60) begin
            chk("word_timeout", bus.sol_valid, 1);
            return;
          end
        end
      end
      chk("wait_quiet", bus.sol_valid, 0);
      chk("wait_no_rd", bus.mem_rd, 0);
      chk("line_reads", rd_cnt - rd0, model_cnt[line]);
      if (rand_ready) bus.sol_ready = 1'b0;
      gap = rand_ready ? int'($urandom_range(0, 2)) : 0;
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        chk("wait_hold", bus.sol_valid, 0);
      end
      if (policy == P_RANDOM && mq.size() != 0) begin
        cnt_we = 1'b1; cnt_idx = IDXW'(mq[0]); cnt_data = CNTW'((model_cnt[mq[0]] + 1) % MAX_OPTS);
        @(negedge clk);
        cnt_we = 1'b0;
      end
      decide(policy, comp, line, pb, pg);
      bus.sol_done = 1'b1; bus.sol_put_back = pb; bus.sol_progress = pg;
      @(negedge clk);
      bus.sol_done = 1'b0; bus.sol_put_back = 1'b0; bus.sol_progress = 1'b0;
      comp++;
      if (pb && !in_q(mq, line)) mq.push_back(line);
      np = pg ? 0 : np + 1;
      if (mq.size() != 0 && np >= mq.size()) begin
        wait_flag("stuck_flag", 1'b1);
        chk("stuck_busy", busy, 0);
        chk("stuck_no_done", done, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          if (bus.sol_valid) seen = 1;
        end
        chk("stuck_quiet", seen, 0);
        return;
      end
    end
  endtask

  initial begin
    int t;
    bus.sol_ready = 1'b0; bus.sol_done = 1'b0; bus.sol_put_back = 1'b0; bus.sol_progress = 1'b0;
    for (int i = 0; i < LINES; i++) model_cnt[i] = 0;
    for (int i = 0; i < LINES*MAX_OPTS; i++) ram[i] = SIZE'($urandom_range(0, 7));
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.sol_valid, 0);
    chk("rst_first", bus.sol_first, 0);
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stuck", stuck, 0);
    rst = 1'b1;

    // 3x3 board 110/010/101: rows are lines 0..2, columns lines 3..5.
    ram[0]  = 3'b110; ram[1]  = 3'b011;
    ram[8]  = 3'b100; ram[9]  = 3'b010; ram[10] = 3'b001;
    ram[16] = 3'b101;
    ram[24] = 3'b101;
    ram[32] = 3'b110; ram[33] = 3'b011;
    ram[40] = 3'b100; ram[41] = 3'b010; ram[42] = 3'b001;
    write_cnt(0, 2); write_cnt(1, 3); write_cnt(2, 1);
    write_cnt(3, 1); write_cnt(4, 2); write_cnt(5, 3);
    run_solve(P_BOARD, 1'b0, 1);
    chk("order_len", order_q.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < order_q.size()) chk("order", order_q[i], exp_order[i]);

    run_solve(P_NOPROG, 1'b0, -1);
    chk("noprog_lines", dut_lines, 6);

    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < LINES*MAX_OPTS; i++) ram[i] = SIZE'($urandom_range(0, 7));
      for (int l = 0; l < LINES; l++) write_cnt(l, int'($urandom_range(0, 11)));
      write_cnt(3, 0);
      if (it == 0) write_cnt(2, 12);
      run_solve(P_RANDOM, 1'b1, -1);
    end

    // Reset while an option word is on the bus.
    write_cnt(0, 3);
    @(negedge clk);
    start = 1'b1;
    bus.sol_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!(bus.sol_valid && !bus.sol_first) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("rst_setup", bus.sol_valid, 1);
    rst = 1'b0;
    #1;
    chk("midrst_valid", bus.sol_valid, 0);
    chk("midrst_mem_rd", bus.mem_rd, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_stuck", stuck, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < LINES; i++) model_cnt[i] = 0;
    run_solve(P_NONE, 1'b1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
